// File: rtl/saes_key_sched.sv
// S-AES key scheduler: expands a 16-bit key into NR+1 round keys, one per clock,
// streams each key as it is written and serves registered random-access table reads.
module saes_key_sched #(
    parameter int NR = 2,
    localparam int IW = $clog2(NR + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   key_in,
    output logic          busy,
    output logic          done,
    output logic          key_ready,
    output logic          rk_valid,
    output logic [IW-1:0] rk_idx,
    output logic [15:0]   rk,
    input  logic [IW-1:0] rd_idx,
    output logic [15:0]   rd_key
);

    // state | meaning
    // IDLE  | waiting for start; table holds last schedule (valid if key_ready)
    // RUN   | writing one round key per edge, indices 1..NR
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NR);

    logic [0:0]    state;
    logic [3:0]    rc;
    logic [IW-1:0] cnt;
    logic [15:0]   prev_key;
    logic [15:0]   next_key;
    logic [7:0]    n_hi;
    logic [15:0]   key_tab [0:NR];

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        y = 4'h0;
        case (x)
            4'h0: y = 4'h9;  4'h1: y = 4'h4;  4'h2: y = 4'hA;  4'h3: y = 4'hB;
            4'h4: y = 4'hD;  4'h5: y = 4'h1;  4'h6: y = 4'h8;  4'h7: y = 4'h5;
            4'h8: y = 4'h6;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'h3;
            4'hC: y = 4'hC;  4'hD: y = 4'hE;  4'hE: y = 4'hF;  4'hF: y = 4'h7;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] xtime(input logic [3:0] b);
        return {b[2:0], 1'b0} ^ (b[3] ? 4'h3 : 4'h0);
    endfunction

    // SubNib(RotNib(w_lo)) folded into the high byte together with the round constant
    always_comb begin
        n_hi     = prev_key[15:8] ^ {rc, 4'h0} ^ {sbox(prev_key[3:0]), sbox(prev_key[7:4])};
        next_key = {n_hi, n_hi ^ prev_key[7:0]};
    end

    assign busy = (state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rc        <= 4'h0;
            cnt       <= '0;
            prev_key  <= 16'h0;
            done      <= 1'b0;
            key_ready <= 1'b0;
            rk_valid  <= 1'b0;
            rk_idx    <= '0;
            rk        <= 16'h0;
            for (int i = 0; i <= NR; i++) key_tab[i] <= 16'h0;
        end else begin
            done     <= 1'b0;
            rk_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        key_tab[0] <= key_in;
                        prev_key   <= key_in;
                        key_ready  <= 1'b0;
                        rc         <= 4'h8;
                        cnt        <= IW'(1);
                        rk_valid   <= 1'b1;
                        rk_idx     <= '0;
                        rk         <= key_in;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    key_tab[cnt] <= next_key;
                    prev_key     <= next_key;
                    rc           <= xtime(rc);
                    cnt          <= cnt + IW'(1);
                    rk_valid     <= 1'b1;
                    rk_idx       <= cnt;
                    rk           <= next_key;
                    if (cnt == LAST_IDX) begin
                        done      <= 1'b1;
                        key_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // out-of-range indices read as zero rather than aliasing into the table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_key <= 16'h0;
        end else if (rd_idx > LAST_IDX) begin
            rd_key <= 16'h0;
        end else begin
            rd_key <= key_tab[rd_idx];
        end
    end

endmodule

// File: tb/tb_saes_key_sched.sv
// Directed bench for saes_key_sched: NR=2, NR=3 and NR=14 instances driven in turn.
module tb_saes_key_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // NR=2 instance
    logic        rst_n_a, start_a, busy_a, done_a, ready_a, valid_a;
    logic [15:0] key_a, rk_a, rd_key_a;
    logic [1:0]  rk_idx_a, rd_a;
    // NR=3 instance
    logic        rst_n_b, start_b, busy_b, done_b, ready_b, valid_b;
    logic [15:0] key_b, rk_b, rd_key_b;
    logic [1:0]  rk_idx_b, rd_b;
    // NR=14 instance
    logic        rst_n_c, start_c, busy_c, done_c, ready_c, valid_c;
    logic [15:0] key_c, rk_c, rd_key_c;
    logic [3:0]  rk_idx_c, rd_c;

    saes_key_sched #(.NR(2)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a), .key_in(key_a),
        .busy(busy_a), .done(done_a), .key_ready(ready_a), .rk_valid(valid_a),
        .rk_idx(rk_idx_a), .rk(rk_a), .rd_idx(rd_a), .rd_key(rd_key_a)
    );
    saes_key_sched #(.NR(3)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b), .key_in(key_b),
        .busy(busy_b), .done(done_b), .key_ready(ready_b), .rk_valid(valid_b),
        .rk_idx(rk_idx_b), .rk(rk_b), .rd_idx(rd_b), .rd_key(rd_key_b)
    );
    saes_key_sched #(.NR(14)) dut_c (
        .clk(clk), .rst_n(rst_n_c), .start(start_c), .key_in(key_c),
        .busy(busy_c), .done(done_c), .key_ready(ready_c), .rk_valid(valid_c),
        .rk_idx(rk_idx_c), .rk(rk_c), .rd_idx(rd_c), .rd_key(rd_key_c)
    );

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model for the long schedule, with the round constants listed by hand
    function automatic logic [3:0] ref_sbox(input logic [3:0] x);
        logic [3:0] tab [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                                 4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
        return tab[x];
    endfunction

    function automatic logic [15:0] ref_round(input logic [15:0] k, input logic [3:0] rcon);
        logic [7:0] hi;
        hi = k[15:8] ^ {rcon, 4'h0} ^ {ref_sbox(k[3:0]), ref_sbox(k[7:4])};
        return {hi, hi ^ k[7:0]};
    endfunction

    logic [3:0]  rc_seq [14] = '{4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5, 4'hA,
                                 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1, 4'h2};
    logic [15:0] model_c [15];

    // single-key NR=2 expansion on dut_a, checking the stream against three expected keys
    task automatic run_a(input logic [15:0] k0, input logic [15:0] k1, input logic [15:0] k2,
                         input string tag);
        start_a = 1'b1; key_a = k0;
        tick();
        start_a = 1'b0;
        check({tag, " busy0"}, 16'(busy_a), 16'h1);
        check({tag, " v0"}, 16'({valid_a, rk_idx_a}), 16'h4);
        check({tag, " rk0"}, rk_a, k0);
        check({tag, " ready0"}, 16'(ready_a), 16'h0);
        tick();
        check({tag, " v1"}, 16'({valid_a, rk_idx_a, done_a}), 16'hA);
        check({tag, " rk1"}, rk_a, k1);
        tick();
        check({tag, " v2"}, 16'({valid_a, rk_idx_a, done_a}), 16'hD);
        check({tag, " rk2"}, rk_a, k2);
        check({tag, " ready2"}, 16'({ready_a, busy_a}), 16'h2);
    endtask

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        key_a = 16'h0;  key_b = 16'h0;  key_c = 16'h0;
        rd_a = '0;      rd_b = '0;      rd_c = '0;
        model_c[0] = 16'hC3A5;
        for (int i = 1; i <= 14; i++) model_c[i] = ref_round(model_c[i-1], rc_seq[i-1]);

        tick(); tick();
        rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
        tick();
        check("rst flags", 16'({busy_a, done_a, ready_a, valid_a}), 16'h0);
        check("rst rk", rk_a, 16'h0);
        check("rst rk_idx", 16'(rk_idx_a), 16'h0);
        check("rst rd_key", rd_key_a, 16'h0);

        // NR=2, key 4AF5
        run_a(16'h4AF5, 16'hDD28, 16'h87AF, "k4af5");
        tick();
        check("post done", 16'({done_a, valid_a, ready_a}), 16'h1);
        check("rk hold", rk_a, 16'h87AF);
        rd_a = 2'd1; tick();
        check("rd1", rd_key_a, 16'hDD28);
        rd_a = 2'd0; tick();
        check("rd0", rd_key_a, 16'h4AF5);

        // NR=2, key 0000 with a stray start mid-expansion, then back-to-back FFFF
        start_a = 1'b1; key_a = 16'h0000;
        tick();
        start_a = 1'b0;
        check("k0 rk0", rk_a, 16'h0000);
        tick();
        check("k0 rk1", rk_a, 16'h1919);
        start_a = 1'b1; key_a = 16'hFFFF;
        tick();
        start_a = 1'b0;
        check("k0 rk2", rk_a, 16'h0D14);
        check("k0 done", 16'({done_a, ready_a, rk_idx_a}), 16'hE);
        rd_a = 2'd3;
        run_a(16'hFFFF, 16'h08F7, 16'h6F98, "kffff");
        check("rd3 oob", rd_key_a, 16'h0000);
        rd_a = 2'd2; tick();
        check("rd2 ffff", rd_key_a, 16'h6F98);

        // reset during expansion aborts to reset values
        start_a = 1'b1; key_a = 16'h4AF5;
        tick();
        start_a = 1'b0;
        tick();
        rst_n_a = 1'b0;
        #1;
        check("arst flags", 16'({busy_a, done_a, ready_a, valid_a}), 16'h0);
        check("arst rk", rk_a, 16'h0);
        check("arst idx", 16'(rk_idx_a), 16'h0);
        check("arst rd", rd_key_a, 16'h0);
        tick();
        rst_n_a = 1'b1;
        tick();
        check("arst after", 16'({busy_a, ready_a, valid_a}), 16'h0);
        rd_a = 2'd1; tick();
        check("arst tab1", rd_key_a, 16'h0);
        rd_a = 2'd0; tick();
        check("arst tab0", rd_key_a, 16'h0);
        run_a(16'h0000, 16'h1919, 16'h0D14, "rerun");

        // NR=3, key 4AF5
        start_b = 1'b1; key_b = 16'h4AF5;
        tick();
        start_b = 1'b0;
        tick(); tick(); tick();
        check("nr3 idx3", 16'({valid_b, rk_idx_b, done_b}), 16'hF);
        check("nr3 rk3", rk_b, 16'h9738);
        rd_b = 2'd3; tick(); check("nr3 rd3", rd_key_b, 16'h9738);
        rd_b = 2'd2; tick(); check("nr3 rd2", rd_key_b, 16'h87AF);
        rd_b = 2'd1; tick(); check("nr3 rd1", rd_key_b, 16'hDD28);
        rd_b = 2'd0; tick(); check("nr3 rd0", rd_key_b, 16'h4AF5);

        // NR=14 against the reference model
        start_c = 1'b1; key_c = model_c[0];
        tick();
        start_c = 1'b0;
        for (int i = 0; i <= 14; i++) begin
            check($sformatf("nr14 v%0d", i), 16'({valid_c, rk_idx_c}), 16'({1'b1, 4'(i)}));
            check($sformatf("nr14 rk%0d", i), rk_c, model_c[i]);
            check($sformatf("nr14 done%0d", i), 16'(done_c), 16'(i == 14));
            tick();
        end
        check("nr14 end", 16'({valid_c, ready_c, busy_c}), 16'h2);
        for (int i = 0; i <= 14; i++) begin
            rd_c = 4'(i);
            tick();
            check($sformatf("nr14 rd%0d", i), rd_key_c, model_c[i]);
        end
        rd_c = 4'd15; tick();
        check("nr14 rd15", rd_key_c, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
